mem_port_arbiter: RTL and testbench

- Shares one single-port instruction/data memory between the IF-stage fetch port and the MEM-stage data port of the ARM pipeline.
- Serialises accesses and arbitrates ties round-robin.
- Drives a pipeline freeze while a data access is outstanding.
- Aborts any memory transaction that never acknowledges, using a watchdog.

---
 rtl/arm_mem_pkg.sv | 14 +
 rtl/mem_port_arbiter_rr_pick2.sv | 20 ++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the IF/MEM single-port memory arbiter.
package arm_mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} arb_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_CNT_W   = 7;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker; on a tie the port that was not granted last wins.
module rr_pick2
  import arm_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic any;

  always_comb begin
    any    = |req;
    gnt_id = PORT_IF;
    if (req[PORT_DM] && (!req[PORT_IF] || last == PORT_IF)) gnt_id = PORT_DM;
    gnt    = {any & gnt_id, any & ~gnt_id};
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM data accesses onto one memory port, with a
// watchdog that aborts transactions that never see mem_ack.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_rd_en,
  input  logic              dm_wr_en,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              err,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
  logic              err_q, err_d;

  logic [1:0]        req, gnt;
  logic              gnt_id;
  logic              rsp_go, rsp_err;
  logic [DATA_W-1:0] rsp_data;

  assign req[PORT_IF] = if_req;
  assign req[PORT_DM] = dm_rd_en | dm_wr_en;

  rr_pick2 u_pick (
    .req    (req),
    .last   (last_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = if_ready_q;
    dm_ready_d  = dm_ready_q;
    err_d       = err_q;
    rsp_go      = 1'b0;
    rsp_err     = 1'b0;
    rsp_data    = '0;

    case (state_q)
      IDLE: if (|gnt) begin
        last_d    = gnt_id;
        cnt_d     = '0;
        mem_req_d = 1'b1;
        if (gnt_id == PORT_DM) begin
          state_d     = BUSY_DM;
          mem_we_d    = dm_wr_en;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else begin
          state_d     = BUSY_IF;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack) begin
          rsp_go = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_go  = 1'b1;
          rsp_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d    = IDLE;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        err_d      = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Writes and aborted accesses return zero data.
    if (rsp_go) begin
      rsp_data  = (mem_we_q || rsp_err) ? '0 : mem_rdata;
      state_d   = RESP;
      mem_req_d = 1'b0;
      err_d     = rsp_err;
      if (state_q == BUSY_DM) begin
        dm_ready_d = 1'b1;
        dm_rdata_d = rsp_data;
      end else begin
        if_ready_d = 1'b1;
        if_rdata_d = rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= PORT_IF;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign err       = err_q;

  // The stall drops in the dm_ready cycle so MEM can retire that instruction.
  assign freeze = (dm_rd_en | dm_wr_en) & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter with a small programmable memory model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, TO = 8, CW = 4;

  typedef struct packed {logic port; logic [DW-1:0] data; logic err;} exp_t;

  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 1'b0, dm_rd_en = 1'b0, dm_wr_en = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic if_ready, dm_ready, err, freeze, mem_req, mem_we, mem_ack;

  logic mem_ack_m = 1'b0, late_ack = 1'b0, zero_wait = 1'b0, ack_en = 1'b1;
  int   ack_delay = 0, wcnt = 0;
  int   checks = 0, errors = 0, cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return a ^ 32'hE3A01015;
  endfunction

  function automatic exp_t mk(input logic p, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.port = p; x.data = d; x.err = e;
    return x;
  endfunction

  assign mem_rdata = rd_fn(mem_addr);
  assign mem_ack   = zero_wait ? mem_req : (mem_ack_m | late_ack);

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .err(err), .freeze(freeze),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Memory model: acks ack_delay cycles after mem_req is first seen.
  initial forever begin
    @(negedge clk);
    if (mem_ack_m || !mem_req) begin
      mem_ack_m = 1'b0; wcnt = 0;
    end else if (ack_en) begin
      wcnt++;
      if (wcnt > ack_delay) mem_ack_m = 1'b1;
    end
  end

  // Scoreboard: every ready pulse must match the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst && (if_ready || dm_ready)) begin
      checks++;
      if (if_ready && dm_ready) begin
        errors++; $display("FAIL both_ready got if_ready=1 dm_ready=1 want one");
      end else if (sb.size() == 0) begin
        errors++; $display("FAIL sb_unexpected got ready if=%0b dm=%0b want none", if_ready, dm_ready);
      end else begin
        e = sb.pop_front();
        if ({dm_ready, dm_ready ? dm_rdata : if_rdata, err} !== {e.port, e.data, e.err}) begin
          errors++;
          $display("FAIL sb_resp got port=%0d data=%h err=%0b want port=%0d data=%h err=%0b",
                   dm_ready, dm_ready ? dm_rdata : if_rdata, err, e.port, e.data, e.err);
        end
      end
    end
  end

  task automatic wait_sig(input int which, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && if_ready) || (which == 1 && dm_ready) || (which == 2 && mem_req)) begin
        got = 1'b1; break;
      end
    end
  endtask

  task automatic test_reset();
    bit got;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, if_ready, dm_ready, err, freeze} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {mem_req, mem_we, if_ready, dm_ready, err, freeze});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want 0", mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    rst = 1'b1; ack_en = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h20;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
      errors++; $display("FAIL busy_before_rst got req=%0b addr=%h want 1 00000020", mem_req, mem_addr);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_async got mem_req=%0b want 0", mem_req);
    end
    @(negedge clk);
    rst = 1'b1; ack_en = 1'b1; ack_delay = 0;
    sb.push_back(mk(1'b0, rd_fn(32'h20), 1'b0));
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
      errors++; $display("FAIL regrant got req=%0b addr=%h want 1 00000020", mem_req, mem_addr);
    end
    wait_sig(0, 10, got);
    checks++;
    if (!got) begin errors++; $display("FAIL regrant_ready got timeout want if_ready"); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    bit got = 1'b0, fz = 1'b0;
    int t_req = -1, t_rdy = -1;
    ack_delay = 2; if_addr = 32'h10; if_req = 1'b1;
    sb.push_back(mk(1'b0, 32'hE3A01005, 1'b0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (freeze) fz = 1'b1;
      if (mem_req && t_req < 0) t_req = cyc;
      if (if_ready) begin got = 1'b1; t_rdy = cyc; break; end
    end
    if_req = 1'b0;
    checks++;
    if (!got || t_rdy - t_req != 3) begin
      errors++; $display("FAIL fetch_latency got got=%0b cycles=%0d want 1 3", got, t_rdy - t_req);
    end
    checks++;
    if (fz) begin errors++; $display("FAIL fetch_freeze got freeze=1 want 0"); end
    @(negedge clk);
  endtask

  task automatic test_write();
    for (int k = 0; k < 2; k++) begin
      bit got = 1'b0, fz_bad = 1'b0, bus_bad = 1'b0, fz_rdy = 1'b1;
      int reqc = 0;
      ack_delay = 3; dm_addr = 32'h400; dm_wdata = 32'hA5A5A5A5;
      dm_wr_en = 1'b1; dm_rd_en = (k == 1);
      sb.push_back(mk(1'b1, '0, 1'b0));
      #1;
      checks++;
      if (freeze !== 1'b1) begin errors++; $display("FAIL wr_freeze_rise got %0b want 1", freeze); end
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (dm_ready) begin got = 1'b1; fz_rdy = freeze; break; end
        if (!freeze) fz_bad = 1'b1;
        if (mem_req) begin
          reqc++;
          if (mem_we !== 1'b1 || mem_addr !== 32'h400 || mem_wdata !== 32'hA5A5A5A5) bus_bad = 1'b1;
        end
      end
      dm_wr_en = 1'b0; dm_rd_en = 1'b0;
      checks++;
      if (!got || reqc != 4) begin
        errors++; $display("FAIL wr_done k=%0d got ready=%0b req_cycles=%0d want 1 4", k, got, reqc);
      end
      checks++;
      if (bus_bad) begin errors++; $display("FAIL wr_bus k=%0d got unstable/wrong bus want we=1 400 A5A5A5A5", k); end
      checks++;
      if (fz_bad || fz_rdy !== 1'b0) begin
        errors++; $display("FAIL wr_freeze k=%0d got drop=%0b at_ready=%0b want 0 0", k, fz_bad, fz_rdy);
      end
      @(negedge clk);
    end
  endtask

  task automatic run_tie(input logic first, input logic [AW-1:0] ia, input logic [AW-1:0] da);
    bit got;
    if_addr = ia; dm_addr = da; if_req = 1'b1; dm_rd_en = 1'b1;
    sb.push_back(first ? mk(1'b1, rd_fn(da), 1'b0) : mk(1'b0, rd_fn(ia), 1'b0));
    sb.push_back(first ? mk(1'b0, rd_fn(ia), 1'b0) : mk(1'b1, rd_fn(da), 1'b0));
    wait_sig(2, 10, got);
    checks++;
    if (!got || mem_addr !== (first ? da : ia)) begin
      errors++; $display("FAIL tie_first got req=%0b addr=%h want 1 %h", got, mem_addr, first ? da : ia);
    end
    wait_sig(int'(first), 20, got);
    checks++;
    if (!got || (!first && freeze !== 1'b1)) begin
      errors++; $display("FAIL tie_first_done got ready=%0b freeze=%0b want 1 %0b", got, freeze, !first);
    end
    if (first) dm_rd_en = 1'b0; else if_req = 1'b0;
    wait_sig(2, 10, got);
    checks++;
    if (!got || mem_addr !== (first ? ia : da)) begin
      errors++; $display("FAIL tie_second got req=%0b addr=%h want 1 %h", got, mem_addr, first ? ia : da);
    end
    wait_sig(int'(!first), 20, got);
    checks++;
    if (!got) begin errors++; $display("FAIL tie_second_done got timeout want ready"); end
    if_req = 1'b0; dm_rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    bit got;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    ack_delay = 1;
    run_tie(1'b1, 32'h100, 32'h200);
    run_tie(1'b1, 32'h104, 32'h204);
    dm_addr = 32'h300; dm_rd_en = 1'b1;
    sb.push_back(mk(1'b1, rd_fn(32'h300), 1'b0));
    wait_sig(1, 20, got);
    checks++;
    if (!got) begin errors++; $display("FAIL dm_only got timeout want dm_ready"); end
    dm_rd_en = 1'b0;
    @(negedge clk);
    run_tie(1'b0, 32'h108, 32'h208);
  endtask

  task automatic test_timeout();
    bit got = 1'b0, bad = 1'b0;
    int busy = 0;
    ack_en = 1'b0; dm_addr = 32'h800; dm_rd_en = 1'b1;
    sb.push_back(mk(1'b1, '0, 1'b1));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dm_ready) begin got = 1'b1; break; end
      if (mem_req) busy++;
      if (!freeze || err) bad = 1'b1;
    end
    dm_rd_en = 1'b0; late_ack = 1'b1; ack_en = 1'b1;
    checks++;
    if (!got || busy != TO) begin
      errors++; $display("FAIL to_busy got ready=%0b busy=%0d want 1 %0d", got, busy, TO);
    end
    checks++;
    if (bad) begin errors++; $display("FAIL to_wait got freeze drop or early err want freeze=1 err=0"); end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) late_ack = 1'b0;
      if (mem_req || if_ready || dm_ready || err) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL late_ack got activity after late ack want idle"); end
  endtask

  task automatic test_back_to_back();
    int n = 0, prev = -1, bad_gap = 0, reqc = 0;
    zero_wait = 1'b1; if_addr = 32'h1000; if_req = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back(mk(1'b0, rd_fn(32'h1000 + 4 * k), 1'b0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) reqc++;
      if (if_ready) begin
        if (prev >= 0 && cyc - prev != 3) bad_gap++;
        prev = cyc; n++;
        if (n == 4) if_req = 1'b0; else if_addr = if_addr + 4;
      end
    end
    zero_wait = 1'b0;
    checks++;
    if (n != 4 || reqc != 4) begin
      errors++; $display("FAIL b2b_count got readies=%0d reqs=%0d want 4 4", n, reqc);
    end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL b2b_gap got %0d bad gaps want 0", bad_gap); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_write();
    test_tie();
    test_timeout();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d pending want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
